// File: rtl/vw_pkg.sv
// rtl/vw_pkg.sv - shared types and helpers for the chunk sequencer
package vw_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Low bit of lane j inside a packed chunk of nbits-wide lanes.
    function automatic int lane_lo(input int j, input int nbits);
        return j * nbits;
    endfunction

endpackage

// File: rtl/vw_chunk_buf.sv
// rtl/vw_chunk_buf.sv - register file, synchronous write, asynchronous read
module vw_chunk_buf #(
    parameter int Depth = 4,
    parameter int Width = 32,
    parameter int AW    = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_in,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_in) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vw_chunk_sequencer.sv
// rtl/vw_chunk_sequencer.sv - loads, runs and drains one vw_matmul vector
module vw_chunk_sequencer
    import vw_pkg::*;
#(
    parameter int InVecLength  = 16,
    parameter int OutVecLength = 8,
    parameter int WorkingRegs  = 4,
    parameter int NBits        = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         up_valid,
    output logic                         up_ready,
    input  logic [WorkingRegs*NBits-1:0] up_data,
    output logic                         mm_in_data_ready,
    output logic [WorkingRegs*NBits-1:0] mm_in_data,
    input  logic                         mm_req_chunk_in,
    input  logic                         mm_req_chunk_ptr_rst,
    input  logic                         mm_req_chunk_out,
    input  logic [NBits-1:0]             mm_write_out_data,
    input  logic                         mm_out_vector_valid,
    output logic                         dn_valid,
    input  logic                         dn_ready,
    output logic [WorkingRegs*NBits-1:0] dn_data,
    output logic                         dn_last,
    output logic                         busy,
    output logic                         err_protocol
);

    localparam int ChunksIn  = ceil_div(InVecLength, WorkingRegs);
    localparam int ChunksOut = ceil_div(OutVecLength, WorkingRegs);
    localparam int CW        = WorkingRegs * NBits;
    localparam int RP_W      = (ChunksIn > 1) ? $clog2(ChunksIn) : 1;
    localparam int OI_W      = (OutVecLength > 1) ? $clog2(OutVecLength) : 1;
    localparam int DP_W      = (ChunksOut > 1) ? $clog2(ChunksOut) : 1;

    localparam logic [RP_W-1:0] InLast  = RP_W'(ChunksIn - 1);
    localparam logic [OI_W-1:0] OutLast = OI_W'(OutVecLength - 1);
    localparam logic [DP_W-1:0] DrnLast = DP_W'(ChunksOut - 1);

    seq_state_t      state_q, state_d;
    logic [RP_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OI_W-1:0] out_idx_q, out_idx_d;
    logic [DP_W-1:0] drain_ptr_q, drain_ptr_d;
    logic            start_q, start_d;
    logic            err_q, err_d;
    logic [NBits-1:0] out_buf_q [OutVecLength];

    logic            accept, out_we, last_wr;
    logic [CW-1:0]   rd_chunk, dn_chunk;

    assign up_ready = (state_q == LOAD) && !rst_in;
    assign accept   = up_valid && up_ready;
    assign out_we   = (state_q == RUN) && mm_req_chunk_out && !rst_in;
    assign last_wr  = out_we && (out_idx_q == OutLast);

    vw_chunk_buf #(.Depth(ChunksIn), .Width(CW), .AW(RP_W)) u_in_buf (
        .clk_in  (clk_in),
        .we_i    (accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (up_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_chunk)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_idx_d   = out_idx_q;
        drain_ptr_d = drain_ptr_q;
        start_d     = 1'b0;
        err_d       = err_q;

        // Stray matmul requests and misplaced end-of-vector flags are ignored but remembered.
        if ((mm_req_chunk_in || mm_req_chunk_ptr_rst || mm_req_chunk_out) && (state_q != RUN)) begin
            err_d = 1'b1;
        end
        if (mm_out_vector_valid && !last_wr) begin
            err_d = 1'b1;
        end

        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (wr_ptr_q == InLast) begin
                        wr_ptr_d = '0;
                        state_d  = RUN;
                        start_d  = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (mm_req_chunk_ptr_rst) begin
                    rd_ptr_d = '0;
                end else if (mm_req_chunk_in) begin
                    rd_ptr_d = (rd_ptr_q == InLast) ? '0 : rd_ptr_q + 1'b1;
                end
                if (last_wr) begin
                    state_d   = DRAIN;
                    rd_ptr_d  = '0;
                    out_idx_d = '0;
                end else if (out_we) begin
                    out_idx_d = out_idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (dn_ready) begin
                    if (drain_ptr_q == DrnLast) begin
                        drain_ptr_d = '0;
                        state_d     = LOAD;
                    end else begin
                        drain_ptr_d = drain_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_idx_q   <= '0;
            drain_ptr_q <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_idx_q   <= out_idx_d;
            drain_ptr_q <= drain_ptr_d;
            start_q     <= start_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (out_we) begin
            out_buf_q[out_idx_q] <= mm_write_out_data;
        end
    end

    // Lanes past the end of the output vector are padded with zero.
    always_comb begin
        dn_chunk = '0;
        for (int j = 0; j < WorkingRegs; j++) begin
            int idx;
            idx = int'(drain_ptr_q) * WorkingRegs + j;
            if (idx < OutVecLength) begin
                dn_chunk[lane_lo(j, NBits) +: NBits] = out_buf_q[idx[OI_W-1:0]];
            end
        end
    end

    assign mm_in_data_ready = start_q && !rst_in;
    assign mm_in_data       = ((state_q == RUN) && !rst_in) ? rd_chunk : '0;
    assign dn_valid         = (state_q == DRAIN) && !rst_in;
    assign dn_data          = dn_valid ? dn_chunk : '0;
    assign dn_last          = dn_valid && (drain_ptr_q == DrnLast);
    assign busy             = (state_q != LOAD) && !rst_in;
    assign err_protocol     = err_q && !rst_in;

endmodule

// File: doc/vw_chunk_sequencer.md
Name: vw_chunk_sequencer

Overview:
- Sequences one vw_matmul instance: buffers an input vector arriving from upstream in WorkingRegs-wide chunks and issues the start strobe.
- Serves chunk reads and pointer-rewind requests, then collects the scalar outputs into an output vector.
- Drains the output vector downstream in WorkingRegs-wide chunks.
- Sits between the layer-to-layer streaming fabric and the matmul datapath.

Parameters:
- InVecLength, 16: elements per input vector.
- OutVecLength, 8: elements per output vector.
- WorkingRegs, 4: lanes per chunk; must match the matmul.
- NBits, 8: bits per element, signed.
- Derived localparams: ChunksIn = ceil(InVecLength/WorkingRegs), ChunksOut = ceil(OutVecLength/WorkingRegs).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, synchronous, active-high
- up_valid  in  1  upstream chunk valid
- up_ready  out  1  upstream chunk accepted when up_valid&up_ready
- up_data  in  WorkingRegs*NBits  input chunk; lane j at bits [(j+1)*NBits-1 : j*NBits]
- mm_in_data_ready  out  1  start strobe to matmul
- mm_in_data  out  WorkingRegs*NBits  current input chunk to matmul
- mm_req_chunk_in  in  1  advance read pointer
- mm_req_chunk_ptr_rst  in  1  rewind read pointer to chunk 0
- mm_req_chunk_out  in  1  capture mm_write_out_data
- mm_write_out_data  in  NBits  scalar output element
- mm_out_vector_valid  in  1  matmul end-of-vector flag
- dn_valid  out  1  output chunk valid
- dn_ready  in  1  downstream accept
- dn_data  out  WorkingRegs*NBits  output chunk, same lane order as up_data
- dn_last  out  1  marks final chunk of the vector
- busy  out  1  state != LOAD
- err_protocol  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_in=1 at posedge):
  - state=LOAD; wr_ptr=rd_ptr=out_idx=drain_ptr=0.
  - All outputs 0, including up_ready (gated while rst_in=1) and err_protocol.
  - Buffer contents are not cleared.
  - Reset mid-operation abandons the vector; nothing is drained.
- States: LOAD, RUN, DRAIN. Type is defined in the package.
- LOAD:
  - up_ready=1.
  - Each accepted beat writes in_buf[wr_ptr] and increments wr_ptr.
  - On acceptance of beat ChunksIn-1 at cycle t: wr_ptr=0, state=RUN at t+1.
  - mm_in_data_ready=1 during cycle t+1 only (single-cycle registered pulse).
- mm_in_data = in_buf[rd_ptr], combinational read. It is valid chunk 0 in the strobe cycle.
- RUN:
  - mm_req_chunk_ptr_rst sets rd_ptr=0.
  - Otherwise mm_req_chunk_in sets rd_ptr+1, wrapping ChunksIn-1 to 0.
  - If both are asserted in the same cycle, rewind wins.
- Output collection (RUN):
  - mm_req_chunk_out (single-cycle pulse) writes out_buf[out_idx]=mm_write_out_data and increments out_idx.
  - The write holding out_idx=OutVecLength-1 at cycle t gives state=DRAIN at t+1, rd_ptr=0, out_idx=0.
  - mm_out_vector_valid must coincide with that last write.
  - mm_out_vector_valid with any other write, or without a write, sets err_protocol; it is otherwise ignored.
- DRAIN:
  - dn_valid=1; dn_data lane j = out_buf[drain_ptr*WorkingRegs+j], or 0 for indices >= OutVecLength.
  - dn_last = (drain_ptr==ChunksOut-1).
  - dn_valid, dn_data and dn_last stay stable while dn_ready=0.
  - On dn_valid&dn_ready: drain_ptr++.
  - After the last beat: drain_ptr=0, state=LOAD next cycle; up_ready=1 that cycle.
- Protocol errors set err_protocol, which is cleared only by reset. In each case the event is ignored and state is unchanged:
  - mm_req_chunk_in, mm_req_chunk_ptr_rst or mm_req_chunk_out outside RUN.
  - up_valid in RUN or DRAIN is not an error; it simply waits (up_ready=0).
- No overlap: loading the next vector does not start until the drain completes.
- Arithmetic: pointers are $clog2(N) bits wide, minimum 1. Elements are stored verbatim; there is no sign extension or truncation.

Decomposition:
- Package vw_pkg:
  - typedef seq_state_t {LOAD, RUN, DRAIN}.
  - function ceil_div(a,b).
  - lane slice helper function.
- Sub-module vw_chunk_buf:
  - Parameterised register file (Depth, Width), synchronous write, asynchronous read.
  - Instantiated once for in_buf.
  - out_buf is an element-addressed register array inside the top module.

Test Plan:
1. InVec16/Out8/WR4, up beats {1,2,3,4},{5..8},{9..12},{13..16} back-to-back -> up_ready falls after the 4th beat; mm_in_data_ready high exactly 1 cycle, the cycle after the 4th beat; mm_in_data={1,2,3,4}.
2. In RUN, three mm_req_chunk_in pulses -> mm_in_data={13..16}. One more pulse -> {1..4} (wrap). Then chunk_in+ptr_rst in the same cycle -> rd_ptr=0, {1..4}.
3. Eight mm_req_chunk_out pulses with data 1..8, mm_out_vector_valid on the 8th -> DRAIN next cycle. dn_data {1,2,3,4} then {5,6,7,8}, dn_last on the 2nd beat. dn_ready held low 3 cycles -> outputs stable. Returns to LOAD after the 2nd accept.
4. OutVecLength=6, writes 10..15 -> beats {10,11,12,13},{14,15,0,0}, dn_last on beat 2.
5. mm_req_chunk_out in LOAD -> err_protocol=1 and stays 1; state LOAD, out_idx 0. Separately, mm_out_vector_valid on the 5th of 8 writes -> err_protocol=1, collection continues to 8.
6. rst_in pulse after 3 output writes in RUN -> next cycle all outputs 0, state LOAD; a new full vector loads and runs to a correct 8-element drain.
